// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand/result bundle between controller and serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow;
  modport master(output start, a, b, input busy, done, diff, borrow);
  modport slave(input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock with start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CW-1:0] cnt;
  logic br, d, br_nx;
  logic [WIDTH-1:0] res_nx;
  always_comb begin
    d = a_sr[0] ^ b_sr[0] ^ br;
    br_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_nx = {d, res_sr};
  end
  assign s.busy = state != IDLE;
  assign s.done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      res_sr <= '0;
      cnt <= '0;
      br <= 1'b0;
      s.diff <= '0;
      s.borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s.start) begin
          a_sr <= s.a;
          b_sr <= s.b;
          br <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br <= br_nx;
          res_sr <= res_nx[WIDTH-1:1];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            s.diff <= res_nx;
            s.borrow <= br_nx;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor at WIDTH=8 and WIDTH=2
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int lat, bcyc, dones, last_done, cyc;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_subtractor_if #(.WIDTH(8)) s8();
  serial_subtractor_if #(.WIDTH(2)) s2();
  serial_subtractor #(.WIDTH(8)) dut8(.clk(clk), .rst_n(rst_n), .s(s8));
  serial_subtractor #(.WIDTH(2)) dut2(.clk(clk), .rst_n(rst_n), .s(s2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit inject,
                      input logic [7:0] hold_d, output int l, output int bc, output int dn);
    @(negedge clk);
    s8.a = a;
    s8.b = b;
    s8.start = 1'b1;
    @(negedge clk);
    s8.start = 1'b0;
    l = -1;
    bc = 0;
    dn = 0;
    for (int n = 0; n < W + 4; n++) begin
      if (n > 0) @(negedge clk);
      if (s8.busy) bc++;
      if (s8.done) begin
        dn++;
        l = n;
      end
      if (inject && n == 4) check("hold_diff", s8.diff, hold_d);
      s8.start = inject && (n == 3 || n == W);
      if (inject) begin
        s8.a = ~a;
        s8.b = 8'd0;
      end
    end
    s8.start = 1'b0;
  endtask
  initial begin
    cyc = 0;
    s8.start = 1'b0; s8.a = '0; s8.b = '0;
    s2.start = 1'b0; s2.a = '0; s2.b = '0;
    #12;
    check("rst_busy", s8.busy, 0);
    check("rst_done", s8.done, 0);
    check("rst_diff", s8.diff, 0);
    check("rst_borrow", s8.borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // basic operation with latency and busy-length checks
    run8(8'd200, 8'd55, 1'b0, 8'd0, lat, bcyc, dones);
    check("t1_lat", lat, W);
    check("t1_busy_cycles", bcyc, W + 1);
    check("t1_dones", dones, 1);
    check("t1_diff", s8.diff, 145);
    check("t1_borrow", s8.borrow, 0);
    run8(8'd5, 8'd10, 1'b0, 8'd0, lat, bcyc, dones);
    check("t2_diff", s8.diff, 251);
    check("t2_borrow", s8.borrow, 1);
    run8(8'd0, 8'd0, 1'b0, 8'd0, lat, bcyc, dones);
    check("t3a_diff", s8.diff, 0);
    check("t3a_borrow", s8.borrow, 0);
    run8(8'd255, 8'd255, 1'b0, 8'd0, lat, bcyc, dones);
    check("t3b_diff", s8.diff, 0);
    check("t3b_borrow", s8.borrow, 0);
    run8(8'd0, 8'd1, 1'b0, 8'd0, lat, bcyc, dones);
    check("t3c_diff", s8.diff, 255);
    check("t3c_borrow", s8.borrow, 1);
    // start pulses while busy plus operand changes after acceptance
    run8(8'd100, 8'd37, 1'b1, 8'd255, lat, bcyc, dones);
    check("t4_lat", lat, W);
    check("t4_dones", dones, 1);
    check("t4_busy_cycles", bcyc, W + 1);
    check("t4_diff", s8.diff, 63);
    check("t4_borrow", s8.borrow, 0);
    // asynchronous abort in the middle of RUN
    @(negedge clk);
    s8.a = 8'd10; s8.b = 8'd3; s8.start = 1'b1;
    @(negedge clk);
    s8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", s8.busy, 0);
    check("t5_done", s8.done, 0);
    check("t5_diff", s8.diff, 0);
    check("t5_borrow", s8.borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'd17, 8'd200, 1'b0, 8'd0, lat, bcyc, dones);
    check("t5_lat", lat, W);
    check("t5_diff", s8.diff, 73);
    check("t5_borrow", s8.borrow, 1);
    // WIDTH=2 exhaustive, back-to-back at the minimum spacing
    last_done = -1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      int k;
      logic [1:0] ea, eb;
      ea = 2'(i >> 2);
      eb = 2'(i);
      s2.a = ea; s2.b = eb; s2.start = 1'b1;
      @(negedge clk);
      s2.start = 1'b0;
      k = 0;
      while (!s2.done && k < 8) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("w2_done_%0d", i), s2.done, 1);
      check($sformatf("w2_diff_%0d", i), s2.diff, 32'(2'(ea - eb)));
      check($sformatf("w2_borrow_%0d", i), s2.borrow, 32'(ea < eb));
      if (last_done >= 0) check($sformatf("w2_spacing_%0d", i), cyc - last_done, 4);
      last_done = cyc;
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
